// File: rtl/seg_display_writer_pkg.sv
// Shared types and constants for the multiplexed seven-segment writer.
package seg_display_writer_pkg;
  `include "seg_defs.vh"

  localparam int NUM_DIGITS = 4;

  // One displayable frame: four hex nibbles plus their decimal points.
  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
  } frame_t;
endpackage

// File: rtl/seg_defs.vh
// Active-low seven-segment patterns {g,f,e,d,c,b,a}, shared by the display blocks.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH
localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
localparam logic [6:0] SEG_HEX_A = 7'b0001000;
localparam logic [6:0] SEG_HEX_B = 7'b0000011;
localparam logic [6:0] SEG_HEX_C = 7'b1000110;
localparam logic [6:0] SEG_HEX_D = 7'b0100001;
localparam logic [6:0] SEG_HEX_E = 7'b0000110;
localparam logic [6:0] SEG_HEX_F = 7'b0001110;
localparam logic [6:0] SEG_OFF   = 7'h7F;
`endif

// File: rtl/seg_display_writer_hex_to_7seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_7seg
  import seg_display_writer_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      default: seg_o = SEG_HEX_F;
    endcase
  end
endmodule

// File: rtl/seg_display_writer.sv
// 4-digit multiplexed seven-segment writer; new values are committed only at
// frame boundaries so a scan never mixes two values.
module seg_display_writer
  import seg_display_writer_pkg::*;
#(
  parameter int CLK_DIV   = 100000,
  parameter int GHOST_CYC = 16,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick,
  output logic        update_pending
);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST    = CNT_W'(GHOST_CYC);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  frame_t           pend_q, pend_d, disp_q, disp_d;
  logic             pend_flag_q, pend_flag_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_q, upd_q;

  logic       slot_end, boundary, lit;
  logic [3:0] digit;
  logic [6:0] dec_seg;
  frame_t     live;

  assign slot_end = (div_cnt_q == DIV_LAST);
  assign boundary = slot_end && (idx_q == 2'd3);
  assign live     = '{val: value, dp: dp_in};
  assign digit    = disp_q.val[4*idx_q +: 4];

  hex_to_7seg u_dec (
    .nib_i (digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    div_cnt_d   = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
    pend_d      = pend_q;
    disp_d      = disp_q;
    pend_flag_d = pend_flag_q;
    if (boundary) begin
      // A load landing on the boundary bypasses the pending buffer entirely.
      if (load)             disp_d = live;
      else if (pend_flag_q) disp_d = pend_q;
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_d      = live;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    lit  = (div_cnt_q >= GHOST) && !blank[idx_q];
    an_d = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec_seg;
      dp_d  = ~disp_q.dp[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      idx_q       <= 2'd0;
      pend_q      <= '0;
      disp_q      <= '0;
      pend_flag_q <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      pend_flag_q <= pend_flag_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      tick_q      <= boundary;
      upd_q       <= pend_flag_q;
    end
  end

  assign an             = an_q;
  assign seg            = seg_q;
  assign dp             = dp_q;
  assign frame_tick     = tick_q;
  assign update_pending = upd_q;
endmodule

// File: tb/tb_seg_display_writer.sv
// Directed bench for seg_display_writer with CLK_DIV=8, GHOST_CYC=2 (32-cycle frame).
module tb_seg_display_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic        update_pending;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  seg_display_writer #(.CLK_DIV(8), .GHOST_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank), .load(load),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // Hold reset 3 edges, release; cycle 0 is the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    run_to(40);
    do_load(16'h8888, 4'hF);
    run_to(45);
    rst = 1'b1;
    repeat (3) tick();
    total++; if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) $display("FAIL reset_out got %h req %h", {an, seg, dp}, {4'hF, 7'h7F, 1'b1}); else passed++;
    total++; if ({frame_tick, update_pending} !== 2'b00) $display("FAIL reset_flags got %b req 00", {frame_tick, update_pending}); else passed++;
    rst = 1'b0;
    cyc = 0;
    run_to(2);
    total++; if (an !== 4'hF) $display("FAIL reset_ghost an got %b req 1111", an); else passed++;
    run_to(3);
    total++; if ({an, seg, dp} !== {4'hE, 7'h40, 1'b1}) $display("FAIL reset_d0 got %h req %h", {an, seg, dp}, {4'hE, 7'h40, 1'b1}); else passed++;
    run_to(35);
    total++; if ({an, seg, update_pending} !== {4'hE, 7'h40, 1'b0}) $display("FAIL reset_discard got %h req %h", {an, seg, update_pending}, {4'hE, 7'h40, 1'b0}); else passed++;
  endtask

  task automatic test_load();
    do_reset();
    run_to(5);
    do_load(16'h1234, 4'b0001);
    run_to(20);
    total++; if (update_pending !== 1'b1) $display("FAIL load_pend_mid got %b req 1", update_pending); else passed++;
    run_to(31);
    total++; if ({update_pending, frame_tick} !== 2'b10) $display("FAIL load_pend_bnd got %b req 10", {update_pending, frame_tick}); else passed++;
    run_to(32);
    total++; if (frame_tick !== 1'b1) $display("FAIL load_tick got %b req 1", frame_tick); else passed++;
    run_to(33);
    total++; if ({an, update_pending} !== {4'hF, 1'b0}) $display("FAIL load_dark0 got %h req %h", {an, update_pending}, {4'hF, 1'b0}); else passed++;
    run_to(34);
    total++; if (an !== 4'hF) $display("FAIL load_dark1 an got %b req 1111", an); else passed++;
    run_to(35);
    total++; if ({an, seg, dp} !== {4'b1110, 7'b0011001, 1'b0}) $display("FAIL load_d0 got %h req %h", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b0}); else passed++;
    run_to(59);
    total++; if ({an, seg, dp} !== {4'b0111, 7'b1111001, 1'b1}) $display("FAIL load_d3 got %h req %h", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1}); else passed++;
  endtask

  task automatic test_blank();
    int bad;
    do_reset();
    blank = 4'b1000;
    run_to(5);
    do_load(16'h00AF, 4'b0000);
    run_to(35);
    total++; if ({an, seg} !== {4'b1110, 7'b0001110}) $display("FAIL blank_d0 got %h req %h", {an, seg}, {4'b1110, 7'b0001110}); else passed++;
    run_to(43);
    total++; if ({an, seg} !== {4'b1101, 7'b0001000}) $display("FAIL blank_d1 got %h req %h", {an, seg}, {4'b1101, 7'b0001000}); else passed++;
    bad = 0;
    while (cyc < 64) begin
      tick();
      if (cyc >= 57 && {an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) bad++;
    end
    total++; if (bad !== 0) $display("FAIL blank_d3 dark-violations got %0d req 0", bad); else passed++;
    blank = 4'b0000;
  endtask

  task automatic test_last_wins();
    do_reset();
    run_to(5);
    do_load(16'h1111, 4'h0);
    run_to(8);
    do_load(16'h2222, 4'h0);
    run_to(32);
    total++; if (update_pending !== 1'b1) $display("FAIL lw_pend got %b req 1", update_pending); else passed++;
    run_to(33);
    total++; if (update_pending !== 1'b0) $display("FAIL lw_clear got %b req 0", update_pending); else passed++;
    run_to(35);
    total++; if ({an, seg} !== {4'b1110, 7'b0100100}) $display("FAIL lw_d0 got %h req %h", {an, seg}, {4'b1110, 7'b0100100}); else passed++;
    run_to(51);
    total++; if ({an, seg} !== {4'b1011, 7'b0100100}) $display("FAIL lw_d2 got %h req %h", {an, seg}, {4'b1011, 7'b0100100}); else passed++;
  endtask

  task automatic test_boundary_load();
    int bad;
    do_reset();
    run_to(31);
    do_load(16'h8888, 4'h0);
    bad = 0;
    while (cyc < 36) begin
      if (update_pending !== 1'b0) bad++;
      tick();
    end
    total++; if (bad !== 0) $display("FAIL bl_pend high-cycles got %0d req 0", bad); else passed++;
    run_to(35);
    total++; if ({an, seg} !== {4'b1110, 7'b0000000}) $display("FAIL bl_d0 got %h req %h", {an, seg}, {4'b1110, 7'b0000000}); else passed++;
  endtask

  task automatic test_free_run();
    int ticks, last, bad_per, overlap, offbad;
    int low[4];
    do_reset();
    ticks = 0; last = 0; bad_per = 0; overlap = 0; offbad = 0;
    for (int i = 0; i < 4; i++) low[i] = 0;
    while (cyc < 128) begin
      tick();
      if (frame_tick === 1'b1) begin
        ticks++;
        if (cyc - last != 32) bad_per++;
        last = cyc;
      end
      for (int i = 0; i < 4; i++) if (an[i] === 1'b0) low[i]++;
      if ($countones(~an) > 1) overlap++;
      if (an === 4'hF && {seg, dp} !== {7'h7F, 1'b1}) offbad++;
    end
    total++; if (ticks !== 4) $display("FAIL fr_ticks got %0d req 4", ticks); else passed++;
    total++; if (bad_per !== 0) $display("FAIL fr_period bad got %0d req 0", bad_per); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (low[i] !== 24) $display("FAIL fr_low%0d got %0d req 24", i, low[i]); else passed++;
    end
    total++; if (overlap !== 0) $display("FAIL fr_overlap got %0d req 0", overlap); else passed++;
    total++; if (offbad !== 0) $display("FAIL fr_offseg got %0d req 0", offbad); else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_blank();
    test_last_wins();
    test_boundary_load();
    test_free_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
